enc_param_ctrl: RTL and testbench

ENC_PARAM_CTRL -- requirements
Module: enc_param_ctrl

---
 rtl/enc_pkg.sv | 18 +
 rtl/btn_debounce.sv | 44 ++++
 rtl/enc_param_ctrl.sv | 149 ++++++++++++++
 tb/tb_enc_param_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// enc_pkg: shared types and constants for the encoder parameter controller.
// Holds the FSM state type, the reset-value helper and the step sizes.
package enc_pkg;

  typedef enum logic [1:0] {
    ST_PRIME = 2'd0,
    ST_IDLE  = 2'd1,
    ST_APPLY = 2'd2
  } state_t;

  localparam int STEP_SLOW = 1;
  localparam int STEP_FAST = 4;

  function automatic int rst_val(input int vmax);
    return vmax / 2;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser + stability filter, one-cycle rise pulse.
// Ports: clk, rst (sync, active-high), i_btn (raw level), o_rise (pulse).
module btn_debounce #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_rise
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;

  // r_cnt counts consecutive cycles where the synced input
  // differs from the accepted level; any agreement restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
      o_rise   <= 1'b0;
    end else begin
      r_s1   <= i_btn;
      r_s2   <= r_s1;
      o_rise <= 1'b0;
      if (r_s2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
        r_stable <= r_s2;
        r_cnt    <= '0;
        o_rise   <= r_s2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/enc_param_ctrl.sv
// enc_param_ctrl: encoder deltas adjust a bank of saturating values;
// a debounced button cycles the selected entry.
// Ports: clk, rst (sync, active-high), count, btn in;
// sel, sel_value, values (flattened), upd_valid, upd_idx out.
// Macro ENC_PARAM_ACCEL_EN: step 4 when APPLYs come within ACCEL_WINDOW.
module enc_param_ctrl
  import enc_pkg::*;
#(
  parameter int CNT_WIDTH    = 8,
  parameter int NUM_PARAMS   = 4,
  parameter int VAL_WIDTH    = 8,
  parameter int VAL_MAX      = 255,
  parameter int DEB_CYCLES   = 50000,
  parameter int ACCEL_WINDOW = 100000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [CNT_WIDTH-1:0]              count,
  input  logic                              btn,
  output logic [$clog2(NUM_PARAMS)-1:0]     sel,
  output logic [VAL_WIDTH-1:0]              sel_value,
  output logic [NUM_PARAMS*VAL_WIDTH-1:0]   values,
  output logic                              upd_valid,
  output logic [$clog2(NUM_PARAMS)-1:0]     upd_idx
);

  localparam int SELW = $clog2(NUM_PARAMS);
  localparam int SW   = VAL_WIDTH + CNT_WIDTH + 3;
  localparam logic [VAL_WIDTH-1:0] RST_VAL =
    VAL_WIDTH'(rst_val(VAL_MAX));
  localparam logic [VAL_WIDTH-1:0] MAX_V = VAL_WIDTH'(VAL_MAX);
  localparam logic signed [SW-1:0] MAX_S = SW'(VAL_MAX);

  if (NUM_PARAMS < 2 || NUM_PARAMS > 16 ||
      DEB_CYCLES < 1 || ACCEL_WINDOW < 1) begin : g_bad_param
    $error("enc_param_ctrl: parameter out of range");
  end

  state_t                r_state;
  logic [CNT_WIDTH-1:0]  r_prev;
  logic [CNT_WIDTH-1:0]  r_delta;
  logic [SELW-1:0]       r_idx;
  logic [SELW-1:0]       r_sel;
  logic [SELW-1:0]       r_upd_idx;
  logic                  r_upd_valid;
  logic [VAL_WIDTH-1:0]  r_vals [NUM_PARAMS];

  logic                  w_rise;
  logic [CNT_WIDTH-1:0]  w_delta;
  logic [SELW-1:0]       w_sel_nxt;
  logic signed [SW-1:0]  w_old;
  logic signed [SW-1:0]  w_inc;
  logic signed [SW-1:0]  w_step;
  logic signed [SW-1:0]  w_sum;
  logic [VAL_WIDTH-1:0]  w_new;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb (
    .clk    (clk),
    .rst    (rst),
    .i_btn  (btn),
    .o_rise (w_rise)
  );

  assign w_delta   = count - r_prev;
  assign w_sel_nxt = (r_sel == SELW'(NUM_PARAMS - 1)) ?
                     '0 : r_sel + 1'b1;

  // Widen old value (unsigned) and delta (signed) before the
  // multiply so neither the product nor the sum can wrap.
  assign w_old = $signed({{(SW-VAL_WIDTH){1'b0}}, r_vals[r_idx]});
  assign w_inc = $signed({{(SW-CNT_WIDTH){r_delta[CNT_WIDTH-1]}},
                          r_delta});
  assign w_sum = w_old + w_inc * w_step;

  always_comb begin
    w_new = '0;
    if (w_sum < 0)          w_new = '0;
    else if (w_sum > MAX_S) w_new = MAX_V;
    else                    w_new = w_sum[VAL_WIDTH-1:0];
  end

`ifdef ENC_PARAM_ACCEL_EN
  localparam int AW_W = $clog2(ACCEL_WINDOW + 1);
  logic [AW_W-1:0] r_acc;

  assign w_step = (r_acc < AW_W'(ACCEL_WINDOW)) ?
                  SW'(STEP_FAST) : SW'(STEP_SLOW);

  always_ff @(posedge clk) begin
    if (rst)                             r_acc <= '0;
    else if (r_state == ST_APPLY)        r_acc <= '0;
    else if (r_acc != AW_W'(ACCEL_WINDOW)) r_acc <= r_acc + 1'b1;
  end
`else
  assign w_step = SW'(STEP_SLOW);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_PRIME;
      r_prev      <= '0;
      r_delta     <= '0;
      r_idx       <= '0;
      r_sel       <= '0;
      r_upd_valid <= 1'b0;
      r_upd_idx   <= '0;
      for (int i = 0; i < NUM_PARAMS; i++) r_vals[i] <= RST_VAL;
    end else begin
      r_upd_valid <= 1'b0;
      if (w_rise) r_sel <= w_sel_nxt;
      unique case (r_state)
        ST_PRIME: begin
          r_prev  <= count;
          r_state <= ST_IDLE;
        end
        ST_IDLE: begin
          r_prev <= count;
          if (w_delta != '0) begin
            r_delta <= w_delta;
            r_idx   <= r_sel;
            r_state <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          // r_prev holds: changes seen here roll into the next delta.
          if (w_new != r_vals[r_idx]) begin
            r_vals[r_idx] <= w_new;
            r_upd_valid   <= 1'b1;
            r_upd_idx     <= r_idx;
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_PRIME;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_PARAMS; g++) begin : g_vals
    assign values[g*VAL_WIDTH +: VAL_WIDTH] = r_vals[g];
  end

  assign sel       = r_sel;
  assign sel_value = r_vals[r_sel];
  assign upd_valid = r_upd_valid;
  assign upd_idx   = r_upd_idx;

endmodule

// File: tb/tb_enc_param_ctrl.sv
// tb_enc_param_ctrl: directed + random stimulus against a
// transaction-level model of the parameter bank.
module tb_enc_param_ctrl;

  localparam int CW  = 8;
  localparam int N   = 4;
  localparam int VW  = 8;
  localparam int VM  = 255;
  localparam int DEB = 8;
  localparam int AW  = 40;
`ifdef ENC_PARAM_ACCEL_EN
  localparam bit ACCEL = 1'b1;
`else
  localparam bit ACCEL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] count = '0;
  logic          btn = 1'b0;
  logic [1:0]    sel;
  logic [VW-1:0] sel_value;
  logic [N*VW-1:0] values;
  logic          upd_valid;
  logic [1:0]    upd_idx;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mvals [N];
  int msel = 0;
  int last_apply = 0;

  enc_param_ctrl #(
    .CNT_WIDTH(CW), .NUM_PARAMS(N), .VAL_WIDTH(VW),
    .VAL_MAX(VM), .DEB_CYCLES(DEB), .ACCEL_WINDOW(AW)
  ) dut (
    .clk(clk), .rst(rst), .count(count), .btn(btn),
    .sel(sel), .sel_value(sel_value), .values(values),
    .upd_valid(upd_valid), .upd_idx(upd_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int dval(int i);
    return int'(values[i*VW +: VW]);
  endfunction

  function automatic int mstep(int gap);
    return (ACCEL && gap <= AW) ? 4 : 1;
  endfunction

  task automatic at_apply(int idx, int d);
    int old;
    int nv;
    old = mvals[idx];
    nv = old + d * mstep(cyc - last_apply);
    last_apply = cyc;
    if (nv < 0) nv = 0;
    if (nv > VM) nv = VM;
    chk("upd_valid", int'(upd_valid), int'(nv != old));
    if (nv != old) chk("upd_idx", int'(upd_idx), idx);
    chk("value", dval(idx), nv);
    mvals[idx] = nv;
  endtask

  task automatic drive_delta(int d);
    logic [7:0] b;
    b = d[7:0];
    count = count + b;
  endtask

  task automatic do_delta(int d);
    int idx;
    idx = msel;
    drive_delta(d);
    @(posedge clk); #1;
    chk("idle_quiet", int'(upd_valid), 0);
    @(posedge clk); #1;
    at_apply(idx, d);
    chk("sel_value", int'(sel_value), mvals[msel]);
    @(posedge clk); #1;
    chk("post_quiet", int'(upd_valid), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) chk("rst_val", dval(i), VM / 2);
    chk("rst_sel", int'(sel), 0);
    chk("rst_valid", int'(upd_valid), 0);
    chk("rst_idx", int'(upd_idx), 0);
    rst = 1'b0;
    last_apply = cyc;
    msel = 0;
    for (int i = 0; i < N; i++) mvals[i] = VM / 2;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic set_val(int target);
    int d;
    for (int k = 0; k < 10 && mvals[msel] != target; k++) begin
      repeat (AW + 2) @(posedge clk);
      #1;
      d = target - mvals[msel];
      if (d > 100) d = 100;
      if (d < -100) d = -100;
      do_delta(d);
    end
  endtask

  task automatic press();
    btn = 1'b1;
    repeat (DEB + 3) @(posedge clk);
    #1;
    btn = 1'b0;
    repeat (DEB + 4) @(posedge clk);
    #1;
    msel = (msel + 1) % N;
    chk("sel_press", int'(sel), msel);
  endtask

  task automatic coincide();
    int idx;
    idx = msel;
    btn = 1'b1;
    repeat (DEB + 1) @(posedge clk);
    #1;
    drive_delta(1);
    @(posedge clk); #1;
    chk("co_sel_pre", int'(sel), idx);
    chk("co_quiet", int'(upd_valid), 0);
    @(posedge clk); #1;
    at_apply(idx, 1);
    msel = (msel + 1) % N;
    chk("co_sel_post", int'(sel), msel);
    btn = 1'b0;
    repeat (DEB + 6) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    int r;
    int idx;
    int v0;
    // PRIME absorbs the count present at reset
    count = 8'h37;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("prime_quiet", int'(upd_valid), 0);
    end
    for (int i = 0; i < N; i++) chk("prime_val", dval(i), 127);

    // 0x10 -> 0x13 on entry 0
    count = 8'h10;
    do_reset();
    repeat (AW + 2) @(posedge clk);
    #1;
    do_delta(3);
    chk("step_130", dval(0), 130);

    // bouncing shorter than the filter, then four clean presses
    for (int k = 0; k < DEB - 1; k++) begin
      btn = ~btn;
      @(posedge clk); #1;
    end
    btn = 1'b0;
    repeat (DEB + 4) @(posedge clk);
    #1;
    chk("bounce_sel", int'(sel), 0);
    press();
    chk("sel_one", int'(sel), 1);
    press();
    press();
    press();
    chk("sel_wrap", int'(sel), 0);

    // saturation at both bounds
    set_val(2);
    repeat (AW + 2) @(posedge clk);
    #1;
    do_delta(-4);
    chk("floor", dval(msel), 0);
    do_delta(-1);
    set_val(254);
    repeat (AW + 2) @(posedge clk);
    #1;
    do_delta(5);
    chk("ceil", dval(msel), 255);

    // press edge lands on the APPLY cycle
    set_val(127);
    repeat (AW + 2) @(posedge clk);
    #1;
    coincide();
    chk("co_sel_one", int'(sel), 1);

    // change arriving during APPLY is carried into the next delta
    idx = msel;
    drive_delta(1);
    @(posedge clk); #1;
    drive_delta(2);
    @(posedge clk); #1;
    at_apply(idx, 1);
    @(posedge clk); #1;
    chk("acc_gap_quiet", int'(upd_valid), 0);
    @(posedge clk); #1;
    at_apply(idx, 2);
    @(posedge clk); #1;

    // acceleration window
    set_val(127);
    repeat (AW + 2) @(posedge clk);
    #1;
    do_delta(1);
    chk("accel_a1", dval(msel), 128);
    repeat (7) @(posedge clk);
    #1;
    do_delta(1);
    chk("accel_a2", dval(msel), ACCEL ? 132 : 129);
    set_val(127);
    repeat (AW + 2) @(posedge clk);
    #1;
    do_delta(1);
    chk("accel_b1", dval(msel), 128);
    repeat (AW + 1) @(posedge clk);
    #1;
    do_delta(1);
    chk("accel_b2", dval(msel), 129);

    // random traffic
    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        press();
      end else begin
        repeat ($urandom_range(0, 50)) @(posedge clk);
        #1;
        d = $urandom_range(1, 30);
        if ($urandom_range(0, 1) == 1) d = -d;
        if ($urandom_range(0, 7) == 0)
          d = int'($urandom_range(0, 255)) - 128;
        if (d == 0) d = 1;
        do_delta(d);
      end
    end
    for (int i = 0; i < N; i++) chk("rand_final", dval(i), mvals[i]);

    // reset during a pending APPLY: no write, no pulse
    idx = msel;
    v0 = mvals[idx];
    if (v0 > 200) d = -5;
    else d = 5;
    drive_delta(d);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_valid", int'(upd_valid), 0);
    chk("abort_val", dval(idx), VM / 2);
    do_reset();
    chk("abort_quiet", int'(upd_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
